// File: rtl/popcount_stream_acc.sv
// Streaming popcount accumulator: sums per-beat set-bit counts over a frame and
// emits the total with a ternary decision against two thresholds.
module popcount_stream_acc #(
  parameter  int WIDTH = 22,
  parameter  int BEATS = 4,
  parameter  int DROP  = 4,
  localparam int CW    = $clog2(WIDTH*BEATS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             approx_en,
  input  logic [CW-1:0]    thr_pos,
  input  logic [CW-1:0]    thr_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [1:0]       out_tern
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [WIDTH-1:0] KEEP_MASK = ~((WIDTH'(1) << DROP) - WIDTH'(1));
  localparam logic [CW-1:0]    BIAS      = CW'(DROP >> 1);

  typedef enum logic [1:0] {ACCEPT, CLOSED, RESULT} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   beat_idx;
  logic            approx_q;
  logic            approx_cur;
  logic            accept;
  logic            frame_end;
  logic [CW-1:0]   beat_val;
  logic            s1_valid;
  logic            s1_last;
  logic [CW-1:0]   s1_cnt;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   total;

  function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] d);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CW'(d[i]);
    return c;
  endfunction

  assign in_ready  = (state == ACCEPT);
  assign accept    = in_valid && in_ready;
  assign frame_end = in_last || (beat_idx == BW'(BEATS-1));
  // Approx mode is taken live on the first beat and from the latch afterwards
  assign approx_cur = (beat_idx == '0) ? approx_en : approx_q;
  assign beat_val   = approx_cur ? popcnt(in_data & KEEP_MASK) + BIAS : popcnt(in_data);
  assign total      = acc + s1_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx <= '0;
      approx_q <= 1'b0;
    end else if (accept) begin
      if (beat_idx == '0) approx_q <= approx_en;
      beat_idx <= frame_end ? '0 : beat_idx + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_cnt   <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept && frame_end;
      s1_cnt   <= accept ? beat_val : '0;
    end
  end

  // Accumulate stage; the result registers only change when a frame closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_tern  <= 2'b00;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (s1_valid) begin
        if (s1_last) begin
          acc       <= '0;
          out_valid <= 1'b1;
          out_count <= total;
          if (total >= thr_pos)     out_tern <= 2'b01;
          else if (total < thr_neg) out_tern <= 2'b11;
          else                      out_tern <= 2'b00;
        end else begin
          acc <= total;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCEPT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCEPT: if (accept && frame_end) state_nxt = CLOSED;
      CLOSED: begin
        if (out_valid && out_ready) state_nxt = ACCEPT;
        else if (out_valid)         state_nxt = RESULT;
      end
      RESULT: if (out_valid && out_ready) state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Randomised self-checking bench for popcount_stream_acc against a frame-level
// reference model built from $countones.
module tb_popcount_stream_acc;

  localparam int WIDTH = 22;
  localparam int BEATS = 4;
  localparam int DROP  = 4;
  localparam int CW    = $clog2(WIDTH*BEATS+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             approx_en = 1'b0;
  logic [CW-1:0]    thr_pos = '0;
  logic [CW-1:0]    thr_neg = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_count;
  logic [1:0]       out_tern;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] frame_data [BEATS];

  popcount_stream_acc #(.WIDTH(WIDTH), .BEATS(BEATS), .DROP(DROP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .approx_en(approx_en),
    .thr_pos(thr_pos), .thr_neg(thr_neg), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_tern(out_tern)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int modelBeat(input logic [WIDTH-1:0] d, input bit apx);
    logic [WIDTH-1:0] keep;
    keep = '1;
    keep = keep << DROP;
    return apx ? $countones(d & keep) + DROP / 2 : $countones(d);
  endfunction

  function automatic logic [1:0] modelTern(input int cnt, input int tp, input int tn);
    if (cnt >= tp) return 2'b01;
    if (cnt < tn)  return 2'b11;
    return 2'b00;
  endfunction

  // Sends n beats from frame_data; approx_en is flipped after the first beat to
  // show the frame keeps its first-beat mode. Returns the modelled frame count.
  task automatic applyStimulus(input int n, input bit apx, input bit use_last, output int exp_cnt);
    int t;
    exp_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = frame_data[i];
      in_last   = use_last && (i == n-1);
      approx_en = (i == 0) ? apx : ~apx;
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) checkOutput("ready_timeout", 0, 1);
      @(posedge clk);
      exp_cnt += modelBeat(frame_data[i], apx);
    end
  endtask

  // Call right after the last accept edge: checks latency, result, hold, release
  task automatic finishFrame(input int exp_cnt, input int hold);
    logic [1:0]    exp_tern;
    exp_tern = modelTern(exp_cnt, thr_pos, thr_neg);
    #1;
    checkOutput("valid_early", out_valid, 0);
    checkOutput("ready_closed", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = WIDTH'($urandom);
    @(posedge clk);
    #1;
    checkOutput("valid_lat2", out_valid, 1);
    checkOutput("count", out_count, exp_cnt);
    checkOutput("tern", out_tern, exp_tern);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_count", out_count, exp_cnt);
      checkOutput("hold_tern", out_tern, exp_tern);
      checkOutput("hold_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_ready", in_ready, 1);
    checkOutput("release_valid", out_valid, 0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    int n;
    bit use_last;
    bit apx;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_count", out_count, 0);
    checkOutput("rst_tern", out_tern, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_ready", in_ready, 1);

    // Full exact frame of all-ones
    thr_pos = 44; thr_neg = 10;
    for (int i = 0; i < BEATS; i++) frame_data[i] = 22'h3FFFFF;
    applyStimulus(4, 1'b0, 1'b0, exp_cnt);
    checkOutput("model_full", exp_cnt, 88);
    finishFrame(exp_cnt, 0);

    // Approx then exact on low-nibble data
    for (int i = 0; i < BEATS; i++) frame_data[i] = 22'h00000F;
    applyStimulus(4, 1'b1, 1'b0, exp_cnt);
    checkOutput("model_approx", exp_cnt, 8);
    finishFrame(exp_cnt, 0);
    applyStimulus(4, 1'b0, 1'b0, exp_cnt);
    finishFrame(exp_cnt, 0);

    // Early close, then a full frame must take all four beats again
    thr_neg = 5;
    frame_data[0] = 22'h3; frame_data[1] = 22'h1;
    applyStimulus(2, 1'b0, 1'b1, exp_cnt);
    checkOutput("model_early", exp_cnt, 3);
    finishFrame(exp_cnt, 5);
    for (int i = 0; i < BEATS; i++) frame_data[i] = 22'h3FFFFF;
    applyStimulus(4, 1'b0, 1'b0, exp_cnt);
    finishFrame(exp_cnt, 0);

    // Reset in the middle of a frame discards the partial sum
    applyStimulus(2, 1'b0, 1'b0, exp_cnt);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_ready", in_ready, 1);
    for (int i = 0; i < BEATS; i++) frame_data[i] = 22'h1;
    applyStimulus(4, 1'b0, 1'b0, exp_cnt);
    checkOutput("model_after_rst", exp_cnt, 4);
    finishFrame(exp_cnt, 0);

    // Random frames
    for (int f = 0; f < 30; f++) begin
      n        = $urandom_range(1, BEATS);
      use_last = (n < BEATS) ? 1'b1 : 1'($urandom_range(0, 1));
      apx      = 1'($urandom_range(0, 1));
      thr_pos  = CW'($urandom_range(0, WIDTH*BEATS));
      thr_neg  = CW'($urandom_range(0, WIDTH*BEATS));
      for (int i = 0; i < BEATS; i++) frame_data[i] = WIDTH'($urandom);
      applyStimulus(n, apx, use_last, exp_cnt);
      finishFrame(exp_cnt, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
